// File: rtl/store_merge_rmw.sv
// store_merge_rmw: executes sb/sh/sw against a word-wide data RAM with no byte
// enables. Word stores are written directly; byte/half stores read the word,
// replace the target lane and write the merged word back.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/ready     request handshake; ready only while IDLE
//   req_op              00 byte, 01 half, 10 word, 11 reserved (rejected)
//   req_addr/req_wdata  byte address and right-aligned store data
//   mem_addr            word-aligned RAM address
//   mem_rd_en/rdata     read strobe, data returns RD_LAT cycles later
//   mem_wr_en/wdata     write strobe and merged write word
//   done, err, busy     completion pulse, reject pulse, not-IDLE status
//
// Build option: STORE_MISALIGN_TRAP_EN makes misaligned half/word requests
// error out; without it they are force-aligned and executed.
module store_merge_rmw #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int unsigned CNT_W = 2;
  localparam logic [1:0]  OP_BYTE = 2'b00;
  localparam logic [1:0]  OP_HALF = 2'b01;
  localparam logic [1:0]  OP_WORD = 2'b10;
  localparam logic [1:0]  OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [1:0]          lane_q, lane_d;
  logic [15:0]         data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                ready_q, rd_en_q, wr_en_q, err_q, busy_q;
  logic                reject_c;
  logic [31:0]         merged_c;

  // Request rejection: reserved op always; misalignment only when trapping.
`ifdef STORE_MISALIGN_TRAP_EN
  assign reject_c = (req_op == OP_RSVD) ||
                    ((req_op == OP_HALF) && req_addr[0]) ||
                    ((req_op == OP_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign reject_c = (req_op == OP_RSVD);
`endif

  // Lane merge of the returning read word; half stores use only lane bit 1,
  // which is what force-aligns a misaligned half.
  always_comb begin
    merged_c = mem_rdata;
    if (op_q == OP_BYTE) begin
      merged_c[{lane_q, 3'b000} +: 8] = data_q[7:0];
    end else begin
      merged_c[{lane_q[1], 4'b0000} +: 16] = data_q;
    end
  end

  // Next-state and captured-request logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    lane_d  = lane_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          lane_d = req_addr[1:0];
          data_d = req_wdata[15:0];
          if (reject_c) begin
            state_d = S_ERR;
          end else begin
            addr_d = {req_addr[ADDR_W-1:2], 2'b00};
            if (req_op == OP_WORD) begin
              wdata_d = req_wdata;
              state_d = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      S_READ: begin
        cnt_d   = CNT_W'(RD_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          wdata_d = merged_c;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; strobes decode the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= (state_d == S_IDLE);
      rd_en_q <= (state_d == S_READ);
      wr_en_q <= (state_d == S_WRITE);
      err_q   <= (state_d == S_ERR);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign req_ready = ready_q;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign mem_wdata = wdata_q;
  assign done      = wr_en_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule
